// File: rtl/calc_seq_engine.sv
// Sequential calculator: ADD/SUB in one step, shift-add MUL and restoring DIV/MOD one bit per cycle.
// Every operation uses a start/DONE handshake; results hold until the next operation completes.
module calc_seq_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           OP,
  input  logic                 SIGNED,
  output logic [2*WIDTH-1:0]   RESULT,
  output logic [WIDTH-1:0]     REMAINDER,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 DIV_BY_ZERO,
  output logic                 OVERFLOW
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIN} state_t;

  state_t r_state, w_next;
  logic   w_accept, w_iter, w_fin;

  logic [WIDTH-1:0] r_a, r_b, r_mag_b, r_work, r_rem, r_q;
  logic [2:0]       r_op;
  logic             r_signed, r_neg_a, r_neg_b;
  logic [W2-1:0]    r_mcand, r_acc;
  logic [CW-1:0]    r_cnt;

  logic [W2-1:0]    r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy, r_done, r_dbz, r_ovf;

  // Operand magnitudes taken at accept time
  logic             w_in_neg_a, w_in_neg_b;
  logic [WIDTH-1:0] w_in_mag_a, w_in_mag_b;

  assign w_in_neg_a = SIGNED & A[WIDTH-1];
  assign w_in_neg_b = SIGNED & B[WIDTH-1];
  assign w_in_mag_a = w_in_neg_a ? (~A + WIDTH'(1)) : A;
  assign w_in_mag_b = w_in_neg_b ? (~B + WIDTH'(1)) : B;

  // Only MUL and non-zero-divisor DIV/MOD need the bit-serial iterations
  logic w_iter_op, w_div_op, w_b_zero;
  assign w_div_op  = (r_op == OP_DIV) || (r_op == OP_MOD);
  assign w_b_zero  = (r_b == '0);
  assign w_iter_op = (r_op == OP_MUL) || (w_div_op && !w_b_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_iter   = 1'b0;
    w_fin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!w_iter_op || (r_cnt == CW'(WIDTH))) begin
          w_fin  = 1'b1;
          w_next = S_FIN;
        end else begin
          w_iter = 1'b1;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Restoring-division step: bring down the next dividend bit, subtract if it fits
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub, w_div_rem_nxt;

  assign w_div_trial   = {r_rem, r_work[WIDTH-1]};
  assign w_div_ge      = (w_div_trial >= {1'b0, r_mag_b});
  assign w_div_sub     = WIDTH'(w_div_trial - {1'b0, r_mag_b});
  assign w_div_rem_nxt = w_div_ge ? w_div_sub : w_div_trial[WIDTH-1:0];

  // Final result formation
  logic [WIDTH:0]   w_ea, w_eb, w_sum, w_qx, w_quot;
  logic [W2-1:0]    w_prod;
  logic [WIDTH:0]   w_prod_hi;
  logic [WIDTH-1:0] w_remv;
  logic [W2-1:0]    w_res;
  logic [WIDTH-1:0] w_rem_out;
  logic             w_dbz, w_ovf;

  assign w_ea      = r_signed ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
  assign w_eb      = r_signed ? {r_b[WIDTH-1], r_b} : {1'b0, r_b};
  assign w_sum     = (r_op == OP_SUB) ? (w_ea - w_eb) : (w_ea + w_eb);
  assign w_prod    = (r_neg_a ^ r_neg_b) ? (~r_acc + W2'(1)) : r_acc;
  assign w_prod_hi = w_prod[W2-1:WIDTH-1];
  // Quotient is kept at WIDTH+1 bits so MIN / -1 yields +2^(WIDTH-1) exactly
  assign w_qx      = {1'b0, r_q};
  assign w_quot    = (r_neg_a ^ r_neg_b) ? (~w_qx + (WIDTH+1)'(1)) : w_qx;
  assign w_remv    = r_neg_a ? (~r_rem + WIDTH'(1)) : r_rem;

  always_comb begin
    w_res     = '0;
    w_rem_out = '0;
    w_dbz     = 1'b0;
    w_ovf     = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res = {{(WIDTH-1){w_sum[WIDTH] & r_signed}}, w_sum};
        w_ovf = r_signed ? (w_sum[WIDTH] ^ w_sum[WIDTH-1]) : w_sum[WIDTH];
      end
      OP_MUL: begin
        w_res = w_prod;
        w_ovf = r_signed ? !((&w_prod_hi) || !(|w_prod_hi)) : (|w_prod[W2-1:WIDTH]);
      end
      OP_DIV, OP_MOD: begin
        if (w_b_zero) begin
          w_res     = '1;
          w_rem_out = r_a;
          w_dbz     = 1'b1;
        end else begin
          w_rem_out = w_remv;
          if (r_op == OP_DIV) begin
            w_res = {{(WIDTH-1){w_quot[WIDTH] & r_signed}}, w_quot};
            w_ovf = r_signed & (w_quot[WIDTH] ^ w_quot[WIDTH-1]);
          end else begin
            w_res = {{WIDTH{w_remv[WIDTH-1] & r_signed}}, w_remv};
          end
        end
      end
      default: ;
    endcase
  end

  // Operand capture, bit-serial datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_signed    <= 1'b0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_mag_b     <= '0;
      r_work      <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_accept) begin
        r_a      <= A;
        r_b      <= B;
        r_op     <= OP;
        r_signed <= SIGNED;
        r_neg_a  <= w_in_neg_a;
        r_neg_b  <= w_in_neg_b;
        r_mag_b  <= w_in_mag_b;
        r_work   <= (OP == OP_MUL) ? w_in_mag_b : w_in_mag_a;
        r_mcand  <= {{WIDTH{1'b0}}, w_in_mag_a};
        r_acc    <= '0;
        r_rem    <= '0;
        r_q      <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_state == S_FIN) begin
        r_busy <= 1'b0;
      end
      if (w_iter) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_op == OP_MUL) begin
          if (r_work[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_work  <= r_work >> 1;
        end else begin
          r_rem  <= w_div_rem_nxt;
          r_q    <= {r_q[WIDTH-2:0], w_div_ge};
          r_work <= r_work << 1;
        end
      end
      if (w_fin) begin
        r_result    <= w_res;
        r_remainder <= w_rem_out;
        r_dbz       <= w_dbz;
        r_ovf       <= w_ovf;
      end
    end
  end

  assign RESULT      = r_result;
  assign REMAINDER   = r_remainder;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign DIV_BY_ZERO = r_dbz;
  assign OVERFLOW    = r_ovf;

endmodule

// File: tb/tb_calc_seq_engine.sv
// Directed self-checking bench for calc_seq_engine at WIDTH=8.
module tb_calc_seq_engine;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n, start, SIGNED;
  logic [7:0]  A, B, REMAINDER;
  logic [2:0]  OP;
  logic [15:0] RESULT;
  logic        BUSY, DONE, DIV_BY_ZERO, OVERFLOW;
  logic [25:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  bit bok;

  assign obs = {RESULT, REMAINDER, DIV_BY_ZERO, OVERFLOW};

  calc_seq_engine #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .OP(OP), .SIGNED(SIGNED),
    .RESULT(RESULT), .REMAINDER(REMAINDER), .BUSY(BUSY), .DONE(DONE),
    .DIV_BY_ZERO(DIV_BY_ZERO), .OVERFLOW(OVERFLOW)
  );

  always #5 clk = ~clk;

  // Issue one operation; returns edges from accept to DONE (-1 on timeout) and whether BUSY stayed high.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input int glitch_at, output int l, output bit busy_ok);
    int guard = 0;
    @(negedge clk);
    while (BUSY && guard < 100) begin @(negedge clk); guard++; end
    A = a; B = b; OP = op; SIGNED = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; OP = OP_ADD; SIGNED = ~sgn;
    busy_ok = BUSY;
    l = -1;
    for (int i = 1; i <= 100; i++) begin
      if (i == glitch_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (!BUSY) busy_ok = 1'b0;
      if (DONE) begin l = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; OP = '0; SIGNED = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({obs, BUSY, DONE} !== 28'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {obs, BUSY, DONE});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    run_op(OP_ADD, 8'd200, 8'd100, 1'b0, 0, lat, bok);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_u_latency: got %0d want 1", lat); end
    n_checks++; if (obs !== {16'h012C, 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL add_u_value: got %h want %h", obs, {16'h012C, 8'h00, 1'b0, 1'b1}); end
    @(posedge clk); #1;
    n_checks++; if ({DONE, BUSY, obs} !== {2'b00, 16'h012C, 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL add_hold: got %h", {DONE, BUSY, obs}); end
    run_op(OP_ADD, 8'd100, 8'd100, 1'b1, 0, lat, bok);
    n_checks++; if (obs !== {16'h00C8, 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL add_s_ovf: got %h want %h", obs, {16'h00C8, 8'h00, 1'b0, 1'b1}); end
  endtask

  task automatic test_sub();
    run_op(OP_SUB, 8'd5, 8'd10, 1'b1, 0, lat, bok);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sub_latency: got %0d want 1", lat); end
    n_checks++; if (obs !== {16'hFFFB, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_s_value: got %h want %h", obs, {16'hFFFB, 8'h00, 1'b0, 1'b0}); end
  endtask

  task automatic test_mul();
    run_op(OP_MUL, 8'hF9, 8'd6, 1'b1, 3, lat, bok);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL mul_latency: got %0d want 9", lat); end
    n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %0d want 1", bok); end
    n_checks++; if (obs !== {16'hFFD6, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mul_s_value: got %h want %h", obs, {16'hFFD6, 8'h00, 1'b0, 1'b0}); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({BUSY, DONE} !== 2'b00) begin
      n_fail++; $display("FAIL mul_start_ignored: busy/done got %b want 00", {BUSY, DONE}); end
    run_op(OP_MUL, 8'd255, 8'd255, 1'b0, 0, lat, bok);
    n_checks++; if (obs !== {16'hFE01, 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL mul_u_ovf: got %h want %h", obs, {16'hFE01, 8'h00, 1'b0, 1'b1}); end
  endtask

  task automatic test_div_mod();
    run_op(OP_DIV, 8'hF3, 8'd4, 1'b1, 0, lat, bok);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL div_latency: got %0d want 9", lat); end
    n_checks++; if (obs !== {16'hFFFD, 8'hFF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL div_s_value: got %h want %h", obs, {16'hFFFD, 8'hFF, 1'b0, 1'b0}); end
    run_op(OP_MOD, 8'd13, 8'd4, 1'b0, 0, lat, bok);
    n_checks++; if (obs !== {16'h0001, 8'h01, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mod_u_value: got %h want %h", obs, {16'h0001, 8'h01, 1'b0, 1'b0}); end
    run_op(OP_MOD, 8'hF3, 8'd4, 1'b1, 0, lat, bok);
    n_checks++; if (obs !== {16'hFFFF, 8'hFF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mod_s_value: got %h want %h", obs, {16'hFFFF, 8'hFF, 1'b0, 1'b0}); end
    run_op(OP_DIV, 8'd200, 8'd7, 1'b0, 0, lat, bok);
    n_checks++; if (obs !== {16'h001C, 8'h04, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL div_u_value: got %h want %h", obs, {16'h001C, 8'h04, 1'b0, 1'b0}); end
  endtask

  task automatic test_div_edge();
    run_op(OP_DIV, 8'd20, 8'd0, 1'b0, 0, lat, bok);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d want 1", lat); end
    n_checks++; if (obs !== {16'hFFFF, 8'd20, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL div0_value: got %h want %h", obs, {16'hFFFF, 8'd20, 1'b1, 1'b0}); end
    run_op(OP_DIV, 8'h80, 8'hFF, 1'b1, 0, lat, bok);
    n_checks++; if (obs !== {16'h0080, 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL div_min_neg1: got %h want %h", obs, {16'h0080, 8'h00, 1'b0, 1'b1}); end
    run_op(OP_RSV, 8'd9, 8'd3, 1'b0, 0, lat, bok);
    n_checks++; if ({lat[7:0], obs} !== {8'd1, 26'h0}) begin
      n_fail++; $display("FAIL reserved_op: got lat %0d obs %h want lat 1 obs 0", lat, obs); end
  endtask

  task automatic test_reset_abort();
    bit saw_done = 1'b0;
    @(negedge clk);
    A = 8'd100; B = 8'd3; OP = OP_DIV; SIGNED = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({obs, BUSY, DONE} !== 28'h0) begin
      n_fail++; $display("FAIL abort_outputs: got %h want 0", {obs, BUSY, DONE}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (DONE) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got 1 want 0"); end
    run_op(OP_ADD, 8'd1, 8'd1, 1'b0, 0, lat, bok);
    n_checks++; if ({lat[7:0], obs} !== {8'd1, 16'h0002, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL abort_next_add: got lat %0d obs %h want lat 1 result 2", lat, obs); end
  endtask

  task automatic test_back_to_back();
    run_op(OP_DIV, 8'd50, 8'd7, 1'b0, 0, lat, bok);
    run_op(OP_SUB, 8'd3, 8'd4, 1'b1, 0, lat, bok);
    n_checks++; if ({lat[7:0], obs} !== {8'd1, 16'hFFFF, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL b2b_sub: got lat %0d obs %h want lat 1 obs %h", lat, obs,
                         {16'hFFFF, 8'h00, 1'b0, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div_mod();
    test_div_edge();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
